// File: rtl/adc_burst_receiver_if.sv
// AXI-Stream sample-word link between the ADC capture core (master) and the
// burst receiver (slave).
interface adc_burst_receiver_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/adc_burst_receiver.sv
// Decodes tagged ADC sample words, frames bursts, buffers {last, a, b} entries
// in a FIFO with a pop-style read port, and keeps burst/error statistics.
module adc_burst_receiver #(
  parameter int unsigned FIFO_ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH       = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  adc_burst_receiver_if.slave        s_axis,
  input  logic                       clear,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [15:0]                rd_a,
  output logic [15:0]                rd_b,
  output logic                       rd_last,
  output logic [FIFO_ADDR_WIDTH:0]   fill_level,
  output logic [15:0]                burst_count,
  output logic [LEN_WIDTH-1:0]       last_burst_len,
  output logic [31:0]                overflow_count,
  output logic [15:0]                tag_error_count,
  output logic [1:0]                 state
);

  localparam int unsigned DEPTH = 2 ** FIFO_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_BURST = 2'd1,
    DROP     = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       ready_q;
  logic [30:0]                mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   fill_q;
  logic [LEN_WIDTH-1:0]       len_q, len_d, len_inc, done_len;

  logic        accept, tag_ok, tag_last, fifo_full, pop, room;
  logic        wr, burst_done, drop, tag_err;
  logic [30:0] head;

  assign s_axis.tready = ready_q;
  assign accept    = s_axis.tvalid && ready_q && !clear;
  assign tag_ok    = s_axis.tdata[31];
  assign tag_last  = s_axis.tdata[30];
  // Occupancy never exceeds DEPTH, so the MSB alone flags a full FIFO.
  assign fifo_full = fill_q[FIFO_ADDR_WIDTH];
  assign pop       = rd_en && (fill_q != '0) && !clear;
  assign room      = !fifo_full || pop;
  assign len_inc   = (len_q == '1) ? len_q : len_q + LEN_WIDTH'(1);
  assign head      = mem[rd_ptr];

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    done_len   = len_q;
    wr         = 1'b0;
    burst_done = 1'b0;
    drop       = 1'b0;
    tag_err    = 1'b0;
    if (accept) begin
      if (!tag_ok) begin
        tag_err = 1'b1;
      end else begin
        unique case (state_q)
          IDLE, IN_BURST: begin
            if (!room) begin
              drop    = 1'b1;
              state_d = tag_last ? IDLE : DROP;
            end else begin
              wr = 1'b1;
              if (tag_last) begin
                burst_done = 1'b1;
                done_len   = (state_q == IDLE) ? LEN_WIDTH'(1) : len_inc;
                state_d    = IDLE;
              end else begin
                len_d   = (state_q == IDLE) ? LEN_WIDTH'(1) : len_inc;
                state_d = IN_BURST;
              end
            end
          end
          DROP: begin
            drop = 1'b1;
            if (tag_last) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (wr) mem[wr_ptr] <= {tag_last, s_axis.tdata[29:0]};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_q         <= 1'b0;
      state_q         <= IDLE;
      len_q           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fill_q          <= '0;
      rd_valid        <= 1'b0;
      rd_a            <= '0;
      rd_b            <= '0;
      rd_last         <= 1'b0;
      burst_count     <= '0;
      last_burst_len  <= '0;
      overflow_count  <= '0;
      tag_error_count <= '0;
    end else begin
      ready_q <= 1'b1;
      if (clear) begin
        state_q         <= IDLE;
        len_q           <= '0;
        wr_ptr          <= '0;
        rd_ptr          <= '0;
        fill_q          <= '0;
        rd_valid        <= 1'b0;
        burst_count     <= '0;
        last_burst_len  <= '0;
        overflow_count  <= '0;
        tag_error_count <= '0;
      end else begin
        state_q  <= state_d;
        len_q    <= len_d;
        rd_valid <= pop;
        if (wr) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr  <= rd_ptr + 1'b1;
          rd_last <= head[30];
          rd_a    <= {head[29], head[29:15]};
          rd_b    <= {head[14], head[14:0]};
        end
        unique case ({wr, pop})
          2'b10:   fill_q <= fill_q + 1'b1;
          2'b01:   fill_q <= fill_q - 1'b1;
          default: fill_q <= fill_q;
        endcase
        if (burst_done) begin
          burst_count    <= burst_count + 16'd1;
          last_burst_len <= done_len;
        end
        if (drop && overflow_count != '1) overflow_count <= overflow_count + 32'd1;
        if (tag_err && tag_error_count != '1) tag_error_count <= tag_error_count + 16'd1;
      end
    end
  end

  assign fill_level = fill_q;
  assign state      = state_q;

endmodule

// File: tb/tb_adc_burst_receiver.sv
// Directed bench for adc_burst_receiver with a 16-entry FIFO.
module tb_adc_burst_receiver;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        clear = 1'b0;
  logic        rd_en = 1'b0;
  logic        rd_valid;
  logic [15:0] rd_a, rd_b;
  logic        rd_last;
  logic [4:0]  fill_level;
  logic [15:0] burst_count;
  logic [15:0] last_burst_len;
  logic [31:0] overflow_count;
  logic [15:0] tag_error_count;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;

  adc_burst_receiver_if axis ();

  adc_burst_receiver #(.FIFO_ADDR_WIDTH(4), .LEN_WIDTH(16)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_axis          (axis),
    .clear           (clear),
    .rd_en           (rd_en),
    .rd_valid        (rd_valid),
    .rd_a            (rd_a),
    .rd_b            (rd_b),
    .rd_last         (rd_last),
    .fill_level      (fill_level),
    .burst_count     (burst_count),
    .last_burst_len  (last_burst_len),
    .overflow_count  (overflow_count),
    .tag_error_count (tag_error_count),
    .state           (state)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    axis.tvalid = 1'b1;
    axis.tdata  = w;
    tick();
    axis.tvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    tick();
    tick();
    chk("rst_tready", 32'(axis.tready), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_a", 32'(rd_a), 0);
    chk("rst_rd_b", 32'(rd_b), 0);
    chk("rst_rd_last", 32'(rd_last), 0);
    chk("rst_fill", 32'(fill_level), 0);
    chk("rst_burst", 32'(burst_count), 0);
    chk("rst_len", 32'(last_burst_len), 0);
    chk("rst_ovf", overflow_count, 0);
    chk("rst_tagerr", 32'(tag_error_count), 0);
    chk("rst_state", 32'(state), 0);

    aresetn = 1'b1;
    chk("tready_before_edge", 32'(axis.tready), 0);
    tick();
    chk("tready_rise", 32'(axis.tready), 1);
    tick();
    chk("tready_hold", 32'(axis.tready), 1);

    // Basic three-word burst
    send(32'h8000_0001);
    send(32'hA000_0000);
    send(32'hC000_7FFF);
    chk("b1_fill", 32'(fill_level), 3);
    chk("b1_burst", 32'(burst_count), 1);
    chk("b1_len", 32'(last_burst_len), 3);
    chk("b1_state", 32'(state), 0);

    rd_en = 1'b1;
    tick();
    chk("p1_valid", 32'(rd_valid), 1);
    chk("p1_a", 32'(rd_a), 32'h0000);
    chk("p1_b", 32'(rd_b), 32'h0001);
    chk("p1_last", 32'(rd_last), 0);
    tick();
    chk("p2_valid", 32'(rd_valid), 1);
    chk("p2_a", 32'(rd_a), 32'hC000);
    chk("p2_b", 32'(rd_b), 32'h0000);
    chk("p2_last", 32'(rd_last), 0);
    tick();
    chk("p3_valid", 32'(rd_valid), 1);
    chk("p3_a", 32'(rd_a), 32'h0000);
    chk("p3_b", 32'(rd_b), 32'hFFFF);
    chk("p3_last", 32'(rd_last), 1);
    chk("p3_fill", 32'(fill_level), 0);
    tick();
    chk("empty_pop_valid", 32'(rd_valid), 0);
    chk("empty_pop_hold_b", 32'(rd_b), 32'hFFFF);
    chk("empty_pop_hold_last", 32'(rd_last), 1);
    chk("empty_pop_fill", 32'(fill_level), 0);
    rd_en = 1'b0;

    // Invalid tags inside a burst
    send(32'h8000_0005);
    chk("inv_state_start", 32'(state), 1);
    send(32'h4000_0000);
    send(32'h0000_0000);
    chk("inv_tagerr", 32'(tag_error_count), 2);
    chk("inv_fill", 32'(fill_level), 1);
    chk("inv_state", 32'(state), 1);
    chk("inv_ovf", overflow_count, 0);
    send(32'hC000_0000);
    chk("inv_burst", 32'(burst_count), 2);
    chk("inv_len", 32'(last_burst_len), 2);
    chk("inv_fill2", 32'(fill_level), 2);
    rd_en = 1'b1;
    tick();
    chk("inv_pop_b", 32'(rd_b), 32'h0005);
    tick();
    chk("inv_pop_last", 32'(rd_last), 1);
    rd_en = 1'b0;
    chk("inv_drained", 32'(fill_level), 0);

    // 20-word burst into a 16-entry FIFO
    for (int i = 1; i <= 19; i++) begin
      send(32'h8000_0000 | 32'(i));
      if (i == 16) begin
        chk("ovf_fill16", 32'(fill_level), 16);
        chk("ovf_ovf0", overflow_count, 0);
        chk("ovf_state_burst", 32'(state), 1);
      end
    end
    chk("ovf_state_drop", 32'(state), 2);
    chk("ovf_ovf3", overflow_count, 3);
    send(32'hC000_0014);
    chk("ovf_ovf4", overflow_count, 4);
    chk("ovf_state_idle", 32'(state), 0);
    chk("ovf_fill", 32'(fill_level), 16);
    chk("ovf_burst_unchanged", 32'(burst_count), 2);
    chk("ovf_len_unchanged", 32'(last_burst_len), 2);

    rd_en = 1'b1;
    tick();
    chk("drain_first_b", 32'(rd_b), 1);
    for (int i = 0; i < 15; i++) tick();
    rd_en = 1'b0;
    chk("drain_last_b", 32'(rd_b), 16);
    chk("drain_no_marker", 32'(rd_last), 0);
    chk("drain_fill", 32'(fill_level), 0);

    send(32'h8000_0000);
    send(32'hC000_0000);
    chk("rec_burst", 32'(burst_count), 3);
    chk("rec_len", 32'(last_burst_len), 2);
    chk("rec_fill", 32'(fill_level), 2);

    // Refill to full, then write and pop in the same cycle
    for (int i = 0; i < 14; i++) send(32'h8000_0020 + 32'(i));
    chk("full_fill", 32'(fill_level), 16);
    chk("full_state", 32'(state), 1);
    rd_en = 1'b1;
    send(32'h8000_0030);
    rd_en = 1'b0;
    chk("rw_fill", 32'(fill_level), 16);
    chk("rw_ovf", overflow_count, 4);
    chk("rw_state", 32'(state), 1);
    chk("rw_valid", 32'(rd_valid), 1);
    chk("rw_b", 32'(rd_b), 0);
    send(32'h8000_0031);
    chk("full_drop_ovf", overflow_count, 5);
    chk("full_drop_state", 32'(state), 2);
    chk("full_drop_fill", 32'(fill_level), 16);

    // Synchronous clear with a word presented and a pop requested
    clear = 1'b1;
    rd_en = 1'b1;
    send(32'h8000_0000);
    clear = 1'b0;
    rd_en = 1'b0;
    chk("clr_fill", 32'(fill_level), 0);
    chk("clr_burst", 32'(burst_count), 0);
    chk("clr_len", 32'(last_burst_len), 0);
    chk("clr_ovf", overflow_count, 0);
    chk("clr_tagerr", 32'(tag_error_count), 0);
    chk("clr_state", 32'(state), 0);
    chk("clr_valid", 32'(rd_valid), 0);
    send(32'hC000_0003);
    chk("clr_next_burst", 32'(burst_count), 1);
    chk("clr_next_len", 32'(last_burst_len), 1);
    chk("clr_next_fill", 32'(fill_level), 1);

    // Asynchronous reset pulse mid-burst
    send(32'h8000_0000);
    chk("ar_pre_state", 32'(state), 1);
    axis.tvalid = 1'b1;
    axis.tdata  = 32'hC000_0000;
    aresetn = 1'b0;
    #1;
    chk("ar_tready", 32'(axis.tready), 0);
    chk("ar_fill", 32'(fill_level), 0);
    chk("ar_state", 32'(state), 0);
    chk("ar_burst", 32'(burst_count), 0);
    chk("ar_len", 32'(last_burst_len), 0);
    #1;
    aresetn = 1'b1;
    tick();
    chk("ar_tready_back", 32'(axis.tready), 1);
    chk("ar_not_accepted", 32'(burst_count), 0);
    chk("ar_not_accepted_fill", 32'(fill_level), 0);
    tick();
    axis.tvalid = 1'b0;
    chk("ar_next_burst", 32'(burst_count), 1);
    chk("ar_next_len", 32'(last_burst_len), 1);
    chk("ar_next_fill", 32'(fill_level), 1);
    chk("ar_next_state", 32'(state), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
